// File: rtl/aes_round_sched_pkg.sv
// Shared AES scheduler definitions: round/slot counts, per-slot state
// encoding and the bit layout of the CPU status word.
package aes_round_sched_pkg;

    localparam int AES_NUM_ROUNDS = 10;  // AES-128 rounds per block
    localparam int AES_NUM_SLOTS  = 4;   // block slots, 2-bit pointer

    typedef enum logic [1:0] {
        SLOT_IDLE     = 2'd0,
        SLOT_READY    = 2'd1,
        SLOT_INFLIGHT = 2'd2
    } slot_state_t;

    // cpu_rd_data bit positions
    localparam int STAT_BUSY_LSB = 0;   // [3:0] slot not IDLE
    localparam int STAT_INFL_LSB = 4;   // [7:4] slot INFLIGHT
    localparam int STAT_ERR_LOAD = 8;   // sticky: load into a busy slot
    localparam int STAT_ERR_RET  = 9;   // sticky: return for a slot not in flight

endpackage

// File: rtl/aes_round_sched_rr_arbiter4.sv
// Four-request round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   req_i        request vector
//   gnt_o        one-hot grant (zero when no request)
//   gnt_vld_o    a grant was issued this cycle
//   gnt_idx_o    index of the granted request
// After reset request 0 has highest priority; after a grant the request
// following the winner becomes highest priority.
module rr_arbiter4 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic       gnt_vld_o,
    output logic [1:0] gnt_idx_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] off;

    always_comb begin
        // Rotate so that bit 0 is the current highest-priority request.
        req_dbl   = {req_i, req_i};
        req_rot   = req_dbl[ptr_q +: 4];
        off       = 2'd0;
        gnt_vld_o = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                off       = 2'(k);
                gnt_vld_o = 1'b1;
            end
        end
        gnt_idx_o = ptr_q + off;
        gnt_o     = gnt_vld_o ? (4'b0001 << gnt_idx_o) : 4'b0000;
        ptr_d     = gnt_vld_o ? (gnt_idx_o + 2'd1) : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= 2'd0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/aes_round_sched.sv
// AES round scheduler: tracks up to four blocks, issues one round per cycle
// to a shared round datapath by round-robin and reports completed blocks.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_vld/in_pntr/in_rdy   load a block into a slot; in_rdy = slot IDLE
//   dp_vld/dp_pntr/dp_round/dp_last  registered round issue
//   ret_vld/ret_pntr        datapath finished a round for a slot
//   done_vld/done_pntr      registered pulse: block fully encrypted
//   cpu_rd/cpu_rd_data      status read; read strobe clears sticky errors
module aes_round_sched
    import aes_round_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int NUM_SLOTS  = AES_NUM_SLOTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vld,
    input  logic [1:0]  in_pntr,
    output logic        in_rdy,
    output logic        dp_vld,
    output logic [1:0]  dp_pntr,
    output logic [3:0]  dp_round,
    output logic        dp_last,
    input  logic        ret_vld,
    input  logic [1:0]  ret_pntr,
    output logic        done_vld,
    output logic [1:0]  done_pntr,
    input  logic        cpu_rd,
    output logic [31:0] cpu_rd_data
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    slot_state_t state_q [NUM_SLOTS];
    slot_state_t state_d [NUM_SLOTS];
    logic [3:0]  cnt_q   [NUM_SLOTS];
    logic [3:0]  cnt_d   [NUM_SLOTS];

    logic       err_load_q, err_load_d, err_ret_q, err_ret_d;
    logic       dp_vld_q, dp_vld_d, dp_last_q, dp_last_d;
    logic [1:0] dp_pntr_q, dp_pntr_d;
    logic [3:0] dp_round_q, dp_round_d;
    logic       done_vld_q, done_vld_d;
    logic [1:0] done_pntr_q, done_pntr_d;

    logic [3:0] req, gnt;
    logic       gnt_vld;
    logic [1:0] gnt_idx;

    always_comb begin
        req = 4'b0000;
        for (int i = 0; i < NUM_SLOTS; i++) req[i] = (state_q[i] == SLOT_READY);
    end

    rr_arbiter4 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // Load, grant and return act on disjoint states (IDLE, READY, INFLIGHT),
    // so at most one of them can change any given slot in a cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_load_d  = err_load_q & ~cpu_rd;
        err_ret_d   = err_ret_q & ~cpu_rd;
        done_vld_d  = 1'b0;
        done_pntr_d = done_pntr_q;

        if (in_vld) begin
            if (state_q[in_pntr] == SLOT_IDLE) begin
                state_d[in_pntr] = SLOT_READY;
                cnt_d[in_pntr]   = 4'd1;
            end else begin
                err_load_d = 1'b1;
            end
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (gnt[i]) state_d[i] = SLOT_INFLIGHT;
        end

        if (ret_vld) begin
            if (state_q[ret_pntr] == SLOT_INFLIGHT) begin
                if (cnt_q[ret_pntr] < LAST_RND) begin
                    cnt_d[ret_pntr]   = cnt_q[ret_pntr] + 4'd1;
                    state_d[ret_pntr] = SLOT_READY;
                end else begin
                    state_d[ret_pntr] = SLOT_IDLE;
                    done_vld_d        = 1'b1;
                    done_pntr_d       = ret_pntr;
                end
            end else begin
                err_ret_d = 1'b1;
            end
        end

        dp_vld_d   = gnt_vld;
        dp_pntr_d  = gnt_vld ? gnt_idx : dp_pntr_q;
        dp_round_d = gnt_vld ? cnt_q[gnt_idx] : dp_round_q;
        dp_last_d  = gnt_vld ? (cnt_q[gnt_idx] == LAST_RND) : dp_last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= SLOT_IDLE;
                cnt_q[i]   <= 4'd0;
            end
            err_load_q  <= 1'b0;
            err_ret_q   <= 1'b0;
            dp_vld_q    <= 1'b0;
            dp_pntr_q   <= 2'd0;
            dp_round_q  <= 4'd0;
            dp_last_q   <= 1'b0;
            done_vld_q  <= 1'b0;
            done_pntr_q <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            err_load_q  <= err_load_d;
            err_ret_q   <= err_ret_d;
            dp_vld_q    <= dp_vld_d;
            dp_pntr_q   <= dp_pntr_d;
            dp_round_q  <= dp_round_d;
            dp_last_q   <= dp_last_d;
            done_vld_q  <= done_vld_d;
            done_pntr_q <= done_pntr_d;
        end
    end

    always_comb begin
        cpu_rd_data = 32'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cpu_rd_data[STAT_BUSY_LSB + i] = (state_q[i] != SLOT_IDLE);
            cpu_rd_data[STAT_INFL_LSB + i] = (state_q[i] == SLOT_INFLIGHT);
        end
        cpu_rd_data[STAT_ERR_LOAD] = err_load_q;
        cpu_rd_data[STAT_ERR_RET]  = err_ret_q;
    end

    assign in_rdy    = (state_q[in_pntr] == SLOT_IDLE);
    assign dp_vld    = dp_vld_q;
    assign dp_pntr   = dp_pntr_q;
    assign dp_round  = dp_round_q;
    assign dp_last   = dp_last_q;
    assign done_vld  = done_vld_q;
    assign done_pntr = done_pntr_q;

endmodule

// File: tb/tb_aes_round_sched.sv
`timescale 1ns/1ps
module tb_aes_round_sched;

    localparam int M_IDLE = 0, M_READY = 1, M_INFL = 2;
    localparam int NR = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_vld, ret_vld, cpu_rd;
    logic [1:0]  in_pntr, ret_pntr;
    logic        in_rdy, dp_vld, dp_last, done_vld;
    logic [1:0]  dp_pntr, done_pntr;
    logic [3:0]  dp_round;
    logic [31:0] cpu_rd_data;

    aes_round_sched dut (
        .clk(clk), .reset(reset),
        .in_vld(in_vld), .in_pntr(in_pntr), .in_rdy(in_rdy),
        .dp_vld(dp_vld), .dp_pntr(dp_pntr), .dp_round(dp_round), .dp_last(dp_last),
        .ret_vld(ret_vld), .ret_pntr(ret_pntr),
        .done_vld(done_vld), .done_pntr(done_pntr),
        .cpu_rd(cpu_rd), .cpu_rd_data(cpu_rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-slot state and round number, last granted slot.
    int m_state [4];
    int m_rnd   [4];
    int m_last;
    bit m_err_load, m_err_ret;
    bit e_dp_vld, e_dp_last, e_done_vld;
    int e_dp_pntr, e_dp_round, e_done_pntr;

    int due [4];
    int cyc;
    int issue_cnt, last_cnt;
    int done_cnt [4];
    int order_q [$];

    typedef struct {
        logic        iv;
        logic [1:0]  ip;
        logic        rv;
        logic [1:0]  rp;
        logic        rd;
        logic        e_rdy;
        logic [31:0] e_stat;
        logic        e_dpv;
        logic [3:0]  e_rnd;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (m_state[i] != M_IDLE) s[i] = 1'b1;
            if (m_state[i] == M_INFL) s[4 + i] = 1'b1;
        end
        s[8] = m_err_load;
        s[9] = m_err_ret;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = M_IDLE;
            m_rnd[i]   = 0;
            due[i]     = -1;
        end
        m_last = 3;
        m_err_load = 1'b0; m_err_ret = 1'b0;
        e_dp_vld = 1'b0; e_dp_last = 1'b0; e_done_vld = 1'b0;
        e_dp_pntr = 0; e_dp_round = 0; e_done_pntr = 0;
    endtask

    task automatic model_step(input logic iv, input int ip, input logic rv, input int rp, input logic rd);
        int old [4];
        int g;
        bit el, er;
        for (int i = 0; i < 4; i++) old[i] = m_state[i];
        g = -1;
        for (int k = 1; k <= 4; k++)
            if (g < 0 && old[(m_last + k) % 4] == M_READY) g = (m_last + k) % 4;
        el = 1'b0; er = 1'b0;
        e_dp_vld = (g >= 0);
        e_done_vld = 1'b0;
        if (g >= 0) begin
            e_dp_pntr  = g;
            e_dp_round = m_rnd[g];
            e_dp_last  = (m_rnd[g] == NR);
            m_state[g] = M_INFL;
            m_last     = g;
        end
        if (iv) begin
            if (old[ip] == M_IDLE) begin m_state[ip] = M_READY; m_rnd[ip] = 1; end
            else el = 1'b1;
        end
        if (rv) begin
            if (old[rp] == M_INFL) begin
                if (m_rnd[rp] < NR) begin m_rnd[rp]++; m_state[rp] = M_READY; end
                else begin m_state[rp] = M_IDLE; e_done_vld = 1'b1; e_done_pntr = rp; end
            end else er = 1'b1;
        end
        m_err_load = (m_err_load && !rd) || el;
        m_err_ret  = (m_err_ret && !rd) || er;
    endtask

    task automatic check_outputs(input int ip);
        chk("in_rdy", 32'(in_rdy), 32'(m_state[ip] == M_IDLE));
        chk("cpu_rd_data", cpu_rd_data, model_status());
        chk("dp_vld", 32'(dp_vld), 32'(e_dp_vld));
        if (e_dp_vld) begin
            chk("dp_pntr", 32'(dp_pntr), 32'(e_dp_pntr));
            chk("dp_round", 32'(dp_round), 32'(e_dp_round));
            chk("dp_last", 32'(dp_last), 32'(e_dp_last));
        end
        chk("done_vld", 32'(done_vld), 32'(e_done_vld));
        if (e_done_vld) chk("done_pntr", 32'(done_pntr), 32'(e_done_pntr));
    endtask

    // Drive one cycle, compare against the model, advance to just after the edge.
    task automatic cycle(input logic iv, input logic [1:0] ip, input logic rv, input logic [1:0] rp, input logic rd);
        in_vld = iv; in_pntr = ip; ret_vld = rv; ret_pntr = rp; cpu_rd = rd;
        #1;
        check_outputs(int'(ip));
        model_step(iv, int'(ip), rv, int'(rp), rd);
        @(posedge clk); #1;
        cyc++;
        if (dp_vld) begin
            issue_cnt++;
            if (dp_last) last_cnt++;
            order_q.push_back(int'(dp_pntr));
        end
        if (done_vld) done_cnt[done_pntr]++;
    endtask

    // Cycle with an emulated datapath returning each issued round lat cycles later.
    task automatic auto_cycle(input logic iv, input logic [1:0] ip, input logic rd, input int lat, input bit bogus);
        logic rv;
        logic [1:0] rp;
        rv = 1'b0; rp = 2'd0;
        if (dp_vld) due[dp_pntr] = cyc + lat;
        for (int s = 0; s < 4; s++)
            if (!rv && due[s] >= 0 && due[s] <= cyc) begin rv = 1'b1; rp = 2'(s); due[s] = -1; end
        if (!rv && bogus && ($urandom % 32 == 0)) begin rv = 1'b1; rp = 2'($urandom % 4); end
        cycle(iv, ip, rv, rp, rd);
    endtask

    task automatic clear_stats();
        issue_cnt = 0; last_cnt = 0; cyc = 0;
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        order_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_vld = 1'b0; in_pntr = 2'd0; ret_vld = 1'b0; ret_pntr = 2'd0; cpu_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        clear_stats();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 32'h000, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h004, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h044, 1'b1, 4'd1};
        tbl[3]  = '{1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 1'b1, 32'h144, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 32'h344, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 32'h044, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h004, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h044, 1'b1, 4'd2};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 32'h244, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 2'd0, 1'b1, 1'b1, 32'h244, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1, 32'h044, 1'b0, 4'd0};

        // Reset values while reset is held
        reset = 1'b1;
        in_vld = 1'b0; in_pntr = 2'd0; ret_vld = 1'b0; ret_pntr = 2'd0; cpu_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dp_vld", 32'(dp_vld), 32'd0);
        chk("rst_dp_pntr", 32'(dp_pntr), 32'd0);
        chk("rst_dp_round", 32'(dp_round), 32'd0);
        chk("rst_dp_last", 32'(dp_last), 32'd0);
        chk("rst_done_vld", 32'(done_vld), 32'd0);
        chk("rst_done_pntr", 32'(done_pntr), 32'd0);
        chk("rst_status", cpu_rd_data, 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        reset = 1'b0;
        model_reset();
        clear_stats();

        // Error scenarios: table of per-cycle inputs and expected outputs
        for (int i = 0; i < 11; i++) begin
            in_vld = tbl[i].iv; in_pntr = tbl[i].ip; ret_vld = tbl[i].rv;
            ret_pntr = tbl[i].rp; cpu_rd = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_status", i), cpu_rd_data, tbl[i].e_stat);
            chk($sformatf("tbl%0d_dp_vld", i), 32'(dp_vld), 32'(tbl[i].e_dpv));
            if (tbl[i].e_dpv) chk($sformatf("tbl%0d_dp_round", i), 32'(dp_round), 32'(tbl[i].e_rnd));
            cycle(tbl[i].iv, tbl[i].ip, tbl[i].rv, tbl[i].rp, tbl[i].rd);
        end

        // Single block in slot 0, return 3 cycles after issue
        do_reset();
        cycle(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        repeat (60) auto_cycle(1'b0, 2'd0, 1'b0, 3, 1'b0);
        chk("single_issues", 32'(issue_cnt), 32'd10);
        chk("single_last", 32'(last_cnt), 32'd1);
        chk("single_done0", 32'(done_cnt[0]), 32'd1);
        chk("single_done_other", 32'(done_cnt[1] + done_cnt[2] + done_cnt[3]), 32'd0);

        // Four slots loaded back to back, return latency 1
        do_reset();
        for (int s = 0; s < 4; s++) auto_cycle(1'b1, 2'(s), 1'b0, 1, 1'b0);
        repeat (80) auto_cycle(1'b0, 2'd0, 1'b0, 1, 1'b0);
        chk("quad_issues", 32'(issue_cnt), 32'd40);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("quad_done%0d", s), 32'(done_cnt[s]), 32'd1);
            if (order_q.size() > s) chk($sformatf("quad_order%0d", s), 32'(order_q[s]), 32'(s));
            else chk($sformatf("quad_order%0d_missing", s), 32'(order_q.size()), 32'(s + 1));
        end

        // Completion and reload of slot 1 in the same cycle
        do_reset();
        cycle(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
        for (int r = 1; r <= 9; r++) begin
            cycle(1'b0, 2'd1, 1'b1, 2'd1, 1'b0);
            cycle(1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
        end
        chk("same_cyc_dp_round", 32'(dp_round), 32'd10);
        chk("same_cyc_dp_last", 32'(dp_last), 32'd1);
        in_vld = 1'b1; in_pntr = 2'd1; ret_vld = 1'b1; ret_pntr = 2'd1; cpu_rd = 1'b0;
        #1;
        chk("same_cyc_in_rdy", 32'(in_rdy), 32'd0);
        cycle(1'b1, 2'd1, 1'b1, 2'd1, 1'b0);
        chk("same_cyc_done_vld", 32'(done_vld), 32'd1);
        chk("same_cyc_done_pntr", 32'(done_pntr), 32'd1);
        chk("same_cyc_status", cpu_rd_data, 32'h100);

        // Reset with slots 0 and 3 in flight at round 5
        do_reset();
        cycle(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            cycle(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
            cycle(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
            cycle(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        end
        chk("midrst_pre_status", cpu_rd_data, 32'h099);
        chk("midrst_pre_round", 32'(dp_round), 32'd5);
        reset = 1'b1;
        #1;
        chk("midrst_dp_vld", 32'(dp_vld), 32'd0);
        chk("midrst_dp_pntr", 32'(dp_pntr), 32'd0);
        chk("midrst_dp_round", 32'(dp_round), 32'd0);
        chk("midrst_dp_last", 32'(dp_last), 32'd0);
        chk("midrst_done_vld", 32'(done_vld), 32'd0);
        chk("midrst_done_pntr", 32'(done_pntr), 32'd0);
        chk("midrst_status", cpu_rd_data, 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        chk("midrst_late_ret", cpu_rd_data, 32'h200);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            auto_cycle(logic'($urandom % 4 == 0), 2'($urandom % 4), logic'($urandom % 16 == 0),
                       1 + int'($urandom % 4), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10: AES-128 round count per block.
REQ-002 SHALL have parameter NUM_SLOTS, default 4: block slots, indexed by the 2-bit pointer number.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_vld  input  1  new block loaded into slot in_pntr (initial AddRoundKey already done).
REQ-006 in_pntr  input  2  slot number of the new block.
REQ-007 in_rdy  output  1  combinational; high when slot in_pntr is IDLE.
REQ-008 dp_vld  output  1  registered; issue one round of slot dp_pntr to the round datapath.
REQ-009 dp_pntr  output  2  registered; slot being issued.
REQ-010 dp_round  output  4  registered; round number 1..NUM_ROUNDS.
REQ-011 dp_last  output  1  registered; high when dp_round==NUM_ROUNDS (datapath bypasses mix_columns).
REQ-012 ret_vld  input  1  datapath finished a round.
REQ-013 ret_pntr  input  2  slot whose round finished.
REQ-014 done_vld  output  1  registered one-cycle pulse; block in done_pntr fully encrypted.
REQ-015 done_pntr  output  2  registered; slot completed.
REQ-016 cpu_rd  input  1  CPU status read strobe.
REQ-017 cpu_rd_data  output  32  combinational status: [3:0] slot busy (not IDLE), [7:4] slot INFLIGHT, [8] sticky bad-load error, [9] sticky bad-return error, [31:10] zero.

Function
REQ-018 Each slot SHALL hold state IDLE, READY, INFLIGHT plus a 4-bit round counter.
REQ-019 in_vld && slot IDLE: slot -> READY, counter = 1, at the next edge.
REQ-020 in_vld && slot not IDLE: load ignored, error bit 8 set.
REQ-021 Each cycle, at most one READY slot SHALL be granted by round-robin (priority starts at slot after last grant; after reset slot 0 highest).
REQ-022 Granted slot -> INFLIGHT at the next edge; same edge drives dp_vld=1, dp_pntr, dp_round=counter, dp_last; dp_vld=0 in cycles with no grant.
REQ-023 Issue latency: block loaded at edge N is READY during cycle N..N+1 and produces dp_vld after edge N+1 at earliest.
REQ-024 ret_vld && slot ret_pntr INFLIGHT && counter<NUM_ROUNDS: counter+1, slot -> READY.
REQ-025 ret_vld && slot INFLIGHT && counter==NUM_ROUNDS: slot -> IDLE, done_vld=1 and done_pntr=ret_pntr at the same edge.
REQ-026 ret_vld for a slot not INFLIGHT: ignored, error bit 9 set.
REQ-027 A slot returning to READY in a cycle SHALL be eligible for grant from the following cycle only.
REQ-028 in_rdy uses current state: a slot completing this cycle accepts a new load no earlier than the next cycle.
REQ-029 Load and return events on different slots in the same cycle SHALL both take effect.
REQ-030 cpu_rd clears sticky bits 8 and 9 at the edge; a simultaneous new error SHALL win (bit stays set).
REQ-031 Counter SHALL never exceed NUM_ROUNDS; no wrap-around.

Reset
REQ-032 On reset: all slots IDLE, counters 0, dp_vld=0, dp_pntr=0, dp_round=0, dp_last=0, done_vld=0, done_pntr=0, error bits 0, round-robin pointer to slot 0.
REQ-033 Reset asserted mid-operation SHALL abandon all in-flight blocks; returns arriving after reset release are treated per REQ-026.

Structure
REQ-034 NUM_ROUNDS, NUM_SLOTS, slot-state encoding and cpu_rd_data bit positions SHALL live in the shared AES defines package.
REQ-035 Round-robin grant SHALL be a sub-module rr_arbiter4 (4 requests, one-hot grant, registered priority pointer).

Verification
REQ-036 Single block slot 0, datapath returning 3 cycles after dp_vld -> dp_round 1..10, dp_last only on round 10, one done_vld with done_pntr=0.
REQ-037 Slots 0-3 loaded on consecutive cycles, return latency 1 -> grants rotate 0,1,2,3; 4x10 issues; four done pulses, each slot exactly once.
REQ-038 in_vld to slot 2 while INFLIGHT -> load ignored, cpu_rd_data[8]=1; cpu_rd -> bit 8 reads 0 next cycle.
REQ-039 ret_vld for IDLE slot 1 -> no state change, cpu_rd_data[9]=1.
REQ-040 Reset asserted while slots 0 and 3 INFLIGHT at round 5 -> all outputs at reset values, cpu_rd_data=0; late ret_vld sets bit 9.
REQ-041 done on slot 1 and in_vld to slot 1 same cycle -> in_rdy=0, load ignored, bit 8 set.
